// File: rtl/pipe_pkg.sv
// Shared defaults and control-word layout for pipeline stage registers.
package pipe_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int CTRL_W_DEF = 16;

   typedef enum logic [3:0] {
      ALU_ADD   = 4'd0,
      ALU_SUB   = 4'd1,
      ALU_AND   = 4'd2,
      ALU_OR    = 4'd3,
      ALU_SLT   = 4'd4,
      ALU_FUNCT = 4'd15
   } alu_op_e;

   // Bit 0 is branch; the upper bits are spare for later stages.
   typedef struct packed {
      logic [5:0] rsvd;
      alu_op_e    alu_op;
      logic       alu_src;
      logic       mem_to_reg;
      logic       reg_write;
      logic       mem_write;
      logic       mem_read;
      logic       branch;
   } stage_ctrl_t;

   localparam logic [CTRL_W_DEF-1:0] CTRL_BUBBLE_DEF = 16'h0000;

   function automatic logic ctrl_has_side_effect(input stage_ctrl_t c);
      return c.branch | c.mem_write | c.reg_write;
   endfunction

endpackage

// File: rtl/pipe_skid_entry.sv
// One overflow entry (valid, data, ctrl) with load and clear, used by the
// skid-buffered build of pipe_stage_reg.
module pipe_skid_entry
   import pipe_pkg::*;
#(
   parameter int                DATA_W      = DATA_W_DEF,
   parameter int                CTRL_W      = CTRL_W_DEF,
   parameter logic [CTRL_W-1:0] CTRL_BUBBLE = CTRL_W'(CTRL_BUBBLE_DEF)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              load,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              valid,
   output logic [DATA_W-1:0] data,
   output logic [CTRL_W-1:0] ctrl
);

   logic              valid_r;
   logic [DATA_W-1:0] data_r;
   logic [CTRL_W-1:0] ctrl_r;

   // Entry register: clear wins over load so a flush never captures input.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_r <= 1'b0;
         data_r  <= {DATA_W{1'b0}};
         ctrl_r  <= CTRL_BUBBLE;
      end else if (clr) begin
         valid_r <= 1'b0;
         ctrl_r  <= CTRL_BUBBLE;
      end else if (load) begin
         valid_r <= 1'b1;
         data_r  <= in_data;
         ctrl_r  <= in_ctrl;
      end
   end

   assign valid = valid_r;
   assign data  = data_r;
   assign ctrl  = ctrl_r;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with flush. Define PIPE_STAGE_SKID_EN
// for a registered-ready main+skid buffer; otherwise a single entry is used.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int                DATA_W      = DATA_W_DEF,
   parameter int                CTRL_W      = CTRL_W_DEF,
   parameter logic [CTRL_W-1:0] CTRL_BUBBLE = CTRL_W'(CTRL_BUBBLE_DEF)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl
);

   logic              main_valid_r;
   logic [DATA_W-1:0] main_data_r;
   logic [CTRL_W-1:0] main_ctrl_r;
   logic              in_xfer_s;
   logic              out_xfer_s;

   assign out_valid  = main_valid_r;
   assign out_data   = main_data_r;
   assign out_ctrl   = main_ctrl_r;
   assign out_xfer_s = main_valid_r && out_ready;

`ifdef PIPE_STAGE_SKID_EN
   logic              in_ready_r;
   logic              main_adv_s;
   logic              skid_load_s;
   logic              skid_clr_s;
   logic              skid_valid_s;
   logic [DATA_W-1:0] skid_data_s;
   logic [CTRL_W-1:0] skid_ctrl_s;

   assign in_ready   = in_ready_r;
   assign in_xfer_s  = in_valid && in_ready_r;
   assign main_adv_s = out_xfer_s || !main_valid_r;

   // Skid fills only while main is stalled; it drains whenever main advances.
   always_comb begin
      skid_load_s = 1'b0;
      skid_clr_s  = 1'b0;
      if (flush) begin
         skid_clr_s = 1'b1;
      end else if (main_adv_s) begin
         skid_clr_s = skid_valid_s;
      end else begin
         skid_load_s = in_xfer_s;
      end
   end

   pipe_skid_entry #(
      .DATA_W      (DATA_W),
      .CTRL_W      (CTRL_W),
      .CTRL_BUBBLE (CTRL_BUBBLE)
   ) u_skid (
      .clk     (clk),
      .rst     (rst),
      .clr     (skid_clr_s),
      .load    (skid_load_s),
      .in_data (in_data),
      .in_ctrl (in_ctrl),
      .valid   (skid_valid_s),
      .data    (skid_data_s),
      .ctrl    (skid_ctrl_s)
   );

   // Main entry: the older skid entry always leaves before new input.
   always_ff @(posedge clk) begin
      if (rst) begin
         main_valid_r <= 1'b0;
         main_data_r  <= {DATA_W{1'b0}};
         main_ctrl_r  <= CTRL_BUBBLE;
      end else if (flush) begin
         main_valid_r <= 1'b0;
         main_ctrl_r  <= CTRL_BUBBLE;
      end else if (main_adv_s) begin
         if (skid_valid_s) begin
            main_valid_r <= 1'b1;
            main_data_r  <= skid_data_s;
            main_ctrl_r  <= skid_ctrl_s;
         end else if (in_xfer_s) begin
            main_valid_r <= 1'b1;
            main_data_r  <= in_data;
            main_ctrl_r  <= in_ctrl;
         end else begin
            main_valid_r <= 1'b0;
            main_ctrl_r  <= CTRL_BUBBLE;
         end
      end
   end

   // Registered ready tracks the skid occupancy after this edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         in_ready_r <= 1'b0;
      end else if (flush) begin
         in_ready_r <= 1'b1;
      end else begin
         in_ready_r <= !(skid_load_s || (skid_valid_s && !skid_clr_s));
      end
   end
`else
   assign in_ready  = (!main_valid_r || out_ready) && !rst;
   assign in_xfer_s = in_valid && in_ready;

   // Single entry: refill on accept, empty to bubble on a bare output transfer.
   always_ff @(posedge clk) begin
      if (rst) begin
         main_valid_r <= 1'b0;
         main_data_r  <= {DATA_W{1'b0}};
         main_ctrl_r  <= CTRL_BUBBLE;
      end else if (flush) begin
         main_valid_r <= 1'b0;
         main_ctrl_r  <= CTRL_BUBBLE;
      end else if (in_xfer_s) begin
         main_valid_r <= 1'b1;
         main_data_r  <= in_data;
         main_ctrl_r  <= in_ctrl;
      end else if (out_xfer_s) begin
         main_valid_r <= 1'b0;
         main_ctrl_r  <= CTRL_BUBBLE;
      end
   end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed table-driven bench for pipe_stage_reg (either buffering mode).
module tb_pipe_stage_reg;

`ifdef PIPE_STAGE_SKID_EN
   localparam bit SKID = 1'b1;
`else
   localparam bit SKID = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic [15:0] in_ctrl;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [15:0] out_ctrl;

   int checks = 0;
   int errors = 0;

   pipe_stage_reg dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_ctrl   (in_ctrl),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_ctrl  (out_ctrl)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        r;
      logic        iv;
      logic [31:0] d;
      logic [15:0] c;
      logic        fl;
      logic        ordy;
      logic        chk_rdy;
      logic        exp_rdy;
      logic        exp_v;
      logic [31:0] exp_d;
      logic [15:0] exp_c;
   } vec_t;

   vec_t tbl[13];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic iv, input logic [31:0] d,
                        input logic [15:0] c, input logic fl, input logic ordy);
      @(negedge clk);
      rst = r; in_valid = iv; in_data = d; in_ctrl = c; flush = fl; out_ready = ordy;
   endtask

   task automatic post_edge;
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(input string name, input logic v, input logic [31:0] d,
                            input logic [15:0] c);
      check({name, "_valid"}, {31'd0, out_valid}, {31'd0, v});
      check({name, "_data"}, out_data, d);
      check({name, "_ctrl"}, {16'd0, out_ctrl}, {16'd0, c});
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = 32'd0; in_ctrl = 16'd0;
      flush = 1'b0; out_ready = 1'b0;

      //         r     iv    d          c         fl    ordy  chk   rdy   v     exp_d      exp_c
      tbl[0]  = '{1'b1, 1'b0, 32'h0,     16'h0,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,     16'h0};
      tbl[1]  = '{1'b1, 1'b1, 32'h77,    16'h7,    1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,     16'h0};
      tbl[2]  = '{1'b0, 1'b0, 32'h0,     16'h0,    1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,     16'h0};
      tbl[3]  = '{1'b0, 1'b1, 32'h100,   16'h0011, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h100,   16'h0011};
      tbl[4]  = '{1'b0, 1'b1, 32'h104,   16'h0012, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h104,   16'h0012};
      tbl[5]  = '{1'b0, 1'b1, 32'h108,   16'h0013, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h108,   16'h0013};
      tbl[6]  = '{1'b0, 1'b0, 32'h0,     16'h0,    1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h108,   16'h0};
      tbl[7]  = '{1'b0, 1'b1, 32'h200,   16'h0044, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h200,   16'h0044};
      tbl[8]  = '{1'b0, 1'b1, 32'hC,     16'h00CC, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h200,   16'h0};
      tbl[9]  = '{1'b0, 1'b0, 32'h0,     16'h0,    1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h200,   16'h0};
      tbl[10] = '{1'b0, 1'b1, 32'h300,   16'h0033, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h300,   16'h0033};
      tbl[11] = '{1'b0, 1'b0, 32'h0,     16'h0,    1'b0, 1'b0, 1'b1, SKID, 1'b1, 32'h300,   16'h0033};
      tbl[12] = '{1'b0, 1'b0, 32'h0,     16'h0,    1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h300,   16'h0};

      for (int i = 0; i < 13; i++) begin
         drive(tbl[i].r, tbl[i].iv, tbl[i].d, tbl[i].c, tbl[i].fl, tbl[i].ordy);
         #1;
         if (tbl[i].chk_rdy)
            check($sformatf("vec%0d_in_ready", i), {31'd0, in_ready}, {31'd0, tbl[i].exp_rdy});
         post_edge();
         check_out($sformatf("vec%0d", i), tbl[i].exp_v, tbl[i].exp_d, tbl[i].exp_c);
      end

      // Stall with 0xA held, offer 0xB, then flush alongside input 0xC.
      drive(1'b0, 1'b1, 32'hA, 16'h00AA, 1'b0, 1'b0);
      post_edge();
      check_out("fl_load", 1'b1, 32'hA, 16'h00AA);
      drive(1'b0, 1'b1, 32'hB, 16'h00BB, 1'b0, 1'b0);
      post_edge();
      check_out("fl_stall", 1'b1, 32'hA, 16'h00AA);
      check("fl_stall_in_ready", {31'd0, in_ready}, 32'd0);
      drive(1'b0, 1'b1, 32'hC, 16'h00CC, 1'b1, 1'b0);
      post_edge();
      check_out("fl_edge", 1'b0, 32'hA, 16'h0);
      check("fl_in_ready", {31'd0, in_ready}, 32'd1);
      drive(1'b0, 1'b0, 32'h0, 16'h0, 1'b0, 1'b1);
      post_edge();
      check_out("fl_after", 1'b0, 32'hA, 16'h0);

      // Reset in the middle of a stall with 0xD held.
      drive(1'b0, 1'b1, 32'hD, 16'h00DD, 1'b0, 1'b0);
      post_edge();
      check_out("rs_load", 1'b1, 32'hD, 16'h00DD);
      drive(1'b0, 1'b0, 32'h0, 16'h0, 1'b0, 1'b0);
      post_edge();
      check_out("rs_stall", 1'b1, 32'hD, 16'h00DD);
      drive(1'b1, 1'b1, 32'hE, 16'h00EE, 1'b1, 1'b1);
      post_edge();
      check_out("rs_edge", 1'b0, 32'h0, 16'h0);
      check("rs_in_ready", {31'd0, in_ready}, 32'd0);
      drive(1'b0, 1'b0, 32'h0, 16'h0, 1'b0, 1'b1);
      post_edge();
      check_out("rs_after", 1'b0, 32'h0, 16'h0);
      check("rs_after_in_ready", {31'd0, in_ready}, 32'd1);

`ifdef PIPE_STAGE_SKID_EN
      // Skid absorbs 0xB during the stall and drains it in order.
      drive(1'b0, 1'b1, 32'hA, 16'h00AA, 1'b0, 1'b0);
      post_edge();
      check_out("sk_a", 1'b1, 32'hA, 16'h00AA);
      drive(1'b0, 1'b1, 32'hB, 16'h00BB, 1'b0, 1'b0);
      post_edge();
      check("sk_full_in_ready", {31'd0, in_ready}, 32'd0);
      drive(1'b0, 1'b1, 32'hF, 16'h00FF, 1'b0, 1'b0);
      post_edge();
      check_out("sk_hold", 1'b1, 32'hA, 16'h00AA);
      drive(1'b0, 1'b0, 32'h0, 16'h0, 1'b0, 1'b1);
      post_edge();
      check_out("sk_b", 1'b1, 32'hB, 16'h00BB);
      check("sk_drain_in_ready", {31'd0, in_ready}, 32'd1);
      drive(1'b0, 1'b0, 32'h0, 16'h0, 1'b0, 1'b1);
      post_edge();
      check_out("sk_empty", 1'b0, 32'hB, 16'h0);

      // Flush with both entries occupied: neither survives.
      drive(1'b0, 1'b1, 32'hA, 16'h00AA, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 32'hB, 16'h00BB, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 32'hC, 16'h00CC, 1'b1, 1'b0);
      post_edge();
      check_out("sk_fl", 1'b0, 32'hA, 16'h0);
      drive(1'b0, 1'b0, 32'h0, 16'h0, 1'b0, 1'b1);
      post_edge();
      check_out("sk_fl_after", 1'b0, 32'hA, 16'h0);
`else
      // Combinational ready follows out_ready and rst within the cycle.
      drive(1'b0, 1'b1, 32'h50, 16'h0055, 1'b0, 1'b0);
      post_edge();
      check_out("nr_load", 1'b1, 32'h50, 16'h0055);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      check("nr_stall_in_ready", {31'd0, in_ready}, 32'd0);
      out_ready = 1'b1;
      #1;
      check("nr_go_in_ready", {31'd0, in_ready}, 32'd1);
      rst = 1'b1;
      #1;
      check("nr_rst_in_ready", {31'd0, in_ready}, 32'd0);
      rst = 1'b0;
      post_edge();
      check_out("nr_drain", 1'b0, 32'h50, 16'h0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
